// File: rtl/sync_fifo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared helpers for sync_fifo_param: log2, pointer width and
//            elaboration-time parameter legality checks.
// Options  : FIFO_FWFT_EN (used by the FIFO and its RAM, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // One extra pointer bit distinguishes full from empty when addresses match.
  localparam int WRAP_BITS = 1;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Pointer width including the wrap bit.
  function automatic int ptr_w(input int add_size);
    return add_size + WRAP_BITS;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  // Depth power of two, address width consistent, thresholds in range.
  function automatic bit params_ok(input int fd, input int add_size,
                                   input int af_lvl, input int ae_lvl);
    return is_pow2(fd) && (add_size == log2(fd)) &&
           (af_lvl >= 1) && (af_lvl <= fd) &&
           (ae_lvl >= 0) && (ae_lvl <= fd - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param_if
// Brief    : Producer/consumer bus of sync_fifo_param. The master modport is
//            the user side; the slave modport is the FIFO side.
// Options  : none (FIFO_FWFT_EN only changes FIFO timing)
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_param_if #(
  parameter int fw       = 8,
  parameter int add_size = 3
);
  logic                wr;
  logic [fw-1:0]       wdata;
  logic                rd;
  logic [fw-1:0]       rdata;
  logic                rvalid;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [add_size:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output wr, wdata, rd,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr, wdata, rd,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Brief    : Simple dual-port RAM, depth x width. Synchronous write port;
//            read port registered, or combinational when FIFO_FWFT_EN is set.
// Options  : FIFO_FWFT_EN - combinational read port
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int depth = 8,
  parameter int width = 8,
  parameter int aw    = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             we,
  input  wire logic [aw-1:0]    waddr,
  input  wire logic [width-1:0] wdata,
  input  wire logic             re,
  input  wire logic [aw-1:0]    raddr,
  output logic      [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Write port; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible without a read strobe; rst and re are not needed.
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rst ^ re;
  assign rdata = mem[raddr];
`else
  // Registered read: old word is returned if the same address is written.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock FIFO with occupancy count, almost-full/empty
//            thresholds, read-valid strobe and overflow/underflow pulses.
// Options  : FIFO_FWFT_EN - first-word-fall-through read (0 latency,
//            rvalid = !empty); default is 1-cycle registered read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int fd       = 8,
  parameter int fw       = 8,
  parameter int add_size = 3,
  parameter int af_lvl   = 6,
  parameter int ae_lvl   = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  sync_fifo_param_if.slave  bus
);

  localparam int PW = ptr_w(add_size);

  if (!params_ok(fd, add_size, af_lvl, ae_lvl)) begin : g_param_check
    $error("sync_fifo_param: illegal fd/add_size/af_lvl/ae_lvl combination");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] count_next;
  logic          full_flag;
  logic          empty_flag;
  logic          af_flag;
  logic          ae_flag;
  logic          ovf_pulse;
  logic          unf_pulse;
  logic          wr_ok;
  logic          rd_ok;
  logic [fw-1:0] mem_rdata;

  // A write into a full FIFO is allowed when a read frees a slot this cycle.
  assign rd_ok      = bus.rd && !empty_flag;
  assign wr_ok      = bus.wr && (!full_flag || rd_ok);
  assign count_next = occupancy + PW'(wr_ok) - PW'(rd_ok);

  // Pointers, count and flags; flags come from count_next so they track count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      full_flag  <= 1'b0;
      empty_flag <= 1'b1;
      af_flag    <= 1'b0;
      ae_flag    <= 1'b1;
      ovf_pulse  <= 1'b0;
      unf_pulse  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      occupancy  <= count_next;
      full_flag  <= (count_next == PW'(fd));
      empty_flag <= (count_next == '0);
      af_flag    <= (count_next >= PW'(af_lvl));
      ae_flag    <= (count_next <= PW'(ae_lvl));
      ovf_pulse  <= bus.wr && !wr_ok;
      unf_pulse  <= bus.rd && !rd_ok;
    end
  end

  fifo_mem #(
    .depth (fd),
    .width (fw),
    .aw    (add_size)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr[add_size-1:0]),
    .wdata (bus.wdata),
    .re    (rd_ok),
    .raddr (rd_ptr[add_size-1:0]),
    .rdata (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head word falls through; an empty FIFO presents zero rather than stale RAM.
  assign bus.rdata  = empty_flag ? '0 : mem_rdata;
  assign bus.rvalid = !empty_flag;
`else
  logic rvalid_flag;

  // One-cycle strobe marking the word popped on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) rvalid_flag <= 1'b0;
    else     rvalid_flag <= rd_ok;
  end

  assign bus.rdata  = mem_rdata;
  assign bus.rvalid = rvalid_flag;
`endif

  assign bus.full         = full_flag;
  assign bus.empty        = empty_flag;
  assign bus.almost_full  = af_flag;
  assign bus.almost_empty = ae_flag;
  assign bus.count        = occupancy;
  assign bus.overflow     = ovf_pulse;
  assign bus.underflow    = unf_pulse;

endmodule
`default_nettype wire
